// File: rtl/dds_tone_mixer_pkg.sv
// Shared types and constants for the DDS tone mixer: FSM states, pan routing
// bits, LUT amplitude and the elaboration-time sine table generator.
package dds_tone_mixer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int PAN_L_BIT = 0;
  localparam int PAN_R_BIT = 1;

  localparam int LUT_AMP   = 32767;
  localparam int LUT_AMP_W = 16;
  localparam int DUR_W     = 16;

  localparam real TWO_PI = 6.283185307179586;

  // Evaluated only at elaboration to fill the ROM. Folds the angle into the
  // first quadrant so the Taylor series stays well inside its accurate range.
  function automatic int sine_entry(input int k, input int addr_w, input int sample_w);
    int  n;
    int  q;
    int  mag;
    bit  neg;
    real x;
    real term;
    real s;
    n   = 1 << addr_w;
    q   = k % n;
    neg = 1'b0;
    if (q >= n / 2) begin
      neg = 1'b1;
      q   = q - n / 2;
    end
    if (q > n / 4) q = n / 2 - q;
    x    = TWO_PI * real'(q) / real'(n);
    term = x;
    s    = x;
    for (int i = 1; i < 14; i++) begin
      term = -term * x * x / real'((2 * i) * (2 * i + 1));
      s    = s + term;
    end
    mag = $rtoi(real'(LUT_AMP) * s + 0.5);
    if (sample_w > LUT_AMP_W)      mag = mag <<< (sample_w - LUT_AMP_W);
    else if (sample_w < LUT_AMP_W) mag = mag >>> (LUT_AMP_W - sample_w);
    return neg ? -mag : mag;
  endfunction

endpackage

// File: rtl/dds_tone_mixer_sine_lut.sv
// Registered sine ROM, one full period of 2^LUT_ADDR_W entries, one cycle of
// read latency.
module tone_sine_lut
  import dds_tone_mixer_pkg::*;
#(
  parameter int LUT_ADDR_W = 8,
  parameter int SAMPLE_W   = 16
) (
  input  logic                         CLOCK_50,
  input  logic                         RST,
  input  logic [LUT_ADDR_W-1:0]        addr,
  output logic signed [SAMPLE_W-1:0]   data
);

  localparam int DEPTH = 2 ** LUT_ADDR_W;

  logic signed [SAMPLE_W-1:0] rom [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_rom
    localparam int VAL = sine_entry(k, LUT_ADDR_W, SAMPLE_W);
    assign rom[k] = SAMPLE_W'(VAL);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) data <= '0;
    else     data <= rom[addr];
  end

endmodule

// File: rtl/dds_tone_mixer.sv
// Multi-voice DDS tone generator: per sample tick, walks the voices through a
// shared sine LUT and gain multiplier and mixes them into saturated L/R outputs.
//
// state    | meaning
// ST_IDLE  | waiting for sample_tick; configuration writes accepted here
// ST_ACCUM | one voice per cycle into the LUT, then one drain cycle
// ST_DONE  | saturate accumulators into outL/outR, retire expired voices
module dds_tone_mixer
  import dds_tone_mixer_pkg::*;
#(
  parameter  int NUM_VOICES = 4,
  parameter  int PHASE_W    = 32,
  parameter  int LUT_ADDR_W = 8,
  parameter  int SAMPLE_W   = 16,
  parameter  int GAIN_W     = 4,
  localparam int VOICE_W    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                       CLOCK_50,
  input  logic                       RST,
  input  logic                       sample_tick,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [VOICE_W-1:0]         cfg_voice,
  input  logic [PHASE_W-1:0]         cfg_incr,
  input  logic [GAIN_W-1:0]          cfg_gain,
  input  logic [1:0]                 cfg_pan,
  input  logic [DUR_W-1:0]           cfg_dur,
  output logic [NUM_VOICES-1:0]      active,
  output logic signed [SAMPLE_W-1:0] outL,
  output logic signed [SAMPLE_W-1:0] outR,
  output logic                       out_valid,
  output logic                       overrun
);

  localparam int ACC_W  = SAMPLE_W + $clog2(NUM_VOICES) + 1;
  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

  localparam logic signed [ACC_W-1:0]    ACC_MAX = ACC_W'((2 ** (SAMPLE_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0]    ACC_MIN = ACC_W'(-(2 ** (SAMPLE_W - 1)));
  localparam logic signed [SAMPLE_W-1:0] OUT_MAX = {1'b0, {(SAMPLE_W - 1){1'b1}}};
  localparam logic signed [SAMPLE_W-1:0] OUT_MIN = {1'b1, {(SAMPLE_W - 1){1'b0}}};

  state_e state;
  state_e state_nxt;

  logic [VOICE_W-1:0] vsel;
  logic               drain;

  logic [PHASE_W-1:0] phase [NUM_VOICES];
  logic [PHASE_W-1:0] incr  [NUM_VOICES];
  logic [GAIN_W-1:0]  gain  [NUM_VOICES];
  logic [1:0]         pan   [NUM_VOICES];
  logic [DUR_W-1:0]   dur   [NUM_VOICES];
  logic [NUM_VOICES-1:0] expire;

  logic tick_accept;
  logic cfg_fire;
  logic voice_step;
  logic last_voice;

  logic [LUT_ADDR_W-1:0]      lut_addr;
  logic signed [SAMPLE_W-1:0] lut_data;

  logic              p_valid;
  logic [GAIN_W-1:0] p_gain;
  logic [1:0]        p_pan;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  contrib;
  logic signed [ACC_W-1:0]  acc_l;
  logic signed [ACC_W-1:0]  acc_r;

  function automatic logic signed [SAMPLE_W-1:0] saturate(input logic signed [ACC_W-1:0] a);
    if (a > ACC_MAX)      return OUT_MAX;
    else if (a < ACC_MIN) return OUT_MIN;
    else                  return SAMPLE_W'(a);
  endfunction

  assign tick_accept = (state == ST_IDLE) && sample_tick;
  assign cfg_ready   = (state == ST_IDLE) && !sample_tick;
  assign cfg_fire    = cfg_valid && cfg_ready && (int'(cfg_voice) < NUM_VOICES);
  assign voice_step  = (state == ST_ACCUM) && !drain;
  assign last_voice  = (vsel == VOICE_W'(NUM_VOICES - 1));
  assign lut_addr    = phase[vsel][PHASE_W-1 -: LUT_ADDR_W];

  always_ff @(posedge CLOCK_50) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (sample_tick) state_nxt = ST_ACCUM;
      ST_ACCUM: if (drain)       state_nxt = ST_DONE;
      ST_DONE:                   state_nxt = ST_IDLE;
      default:                   state_nxt = ST_IDLE;
    endcase
  end

  // drain marks the extra ACCUM cycle in which the last LUT read lands
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      vsel  <= '0;
      drain <= 1'b0;
    end else if (tick_accept) begin
      vsel  <= '0;
      drain <= 1'b0;
    end else if (voice_step) begin
      if (last_voice) drain <= 1'b1;
      else            vsel  <= vsel + VOICE_W'(1);
    end
  end

  tone_sine_lut #(
    .LUT_ADDR_W (LUT_ADDR_W),
    .SAMPLE_W   (SAMPLE_W)
  ) u_lut (
    .CLOCK_50 (CLOCK_50),
    .RST      (RST),
    .addr     (lut_addr),
    .data     (lut_data)
  );

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      p_valid <= 1'b0;
      p_gain  <= '0;
      p_pan   <= '0;
    end else begin
      p_valid <= voice_step && active[vsel];
      p_gain  <= gain[vsel];
      p_pan   <= pan[vsel];
    end
  end

  // Arithmetic shift of the signed product floors toward minus infinity.
  assign prod    = PROD_W'(lut_data) * PROD_W'($signed({1'b0, p_gain}));
  assign contrib = ACC_W'(prod >>> GAIN_W);

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      acc_l <= '0;
      acc_r <= '0;
    end else if (tick_accept) begin
      acc_l <= '0;
      acc_r <= '0;
    end else if (p_valid) begin
      if (p_pan[PAN_L_BIT]) acc_l <= acc_l + contrib;
      if (p_pan[PAN_R_BIT]) acc_r <= acc_r + contrib;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      outL      <= '0;
      outR      <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= (state == ST_DONE);
      overrun   <= sample_tick && (state != ST_IDLE);
      if (state == ST_DONE) begin
        outL <= saturate(acc_l);
        outR <= saturate(acc_r);
      end
    end
  end

  // dur counts down per produced sample; the voice retires at DONE of the
  // sample in which it reached terminal count, so exactly dur samples sound.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase[v] <= '0;
        incr[v]  <= '0;
        gain[v]  <= '0;
        pan[v]   <= '0;
        dur[v]   <= '0;
      end
      active <= '0;
      expire <= '0;
    end else begin
      if (cfg_fire) begin
        phase[cfg_voice]  <= '0;
        incr[cfg_voice]   <= cfg_incr;
        gain[cfg_voice]   <= cfg_gain;
        pan[cfg_voice]    <= cfg_pan;
        dur[cfg_voice]    <= cfg_dur;
        active[cfg_voice] <= (cfg_gain != '0);
        expire[cfg_voice] <= 1'b0;
      end
      if (voice_step && active[vsel]) begin
        phase[vsel] <= phase[vsel] + incr[vsel];
        if (dur[vsel] != '0) begin
          dur[vsel] <= dur[vsel] - DUR_W'(1);
          if (dur[vsel] == DUR_W'(1)) expire[vsel] <= 1'b1;
        end
      end
      if (state == ST_DONE) begin
        active <= active & ~expire;
        expire <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dds_tone_mixer.sv
// Scoreboard bench for dds_tone_mixer: a behavioural voice model predicts each
// sample at tick time; the monitor compares when out_valid pulses.
module tb_dds_tone_mixer;

  localparam int NV = 4;

  logic               CLOCK_50 = 1'b0;
  logic               RST;
  logic               sample_tick;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [1:0]         cfg_voice;
  logic [31:0]        cfg_incr;
  logic [3:0]         cfg_gain;
  logic [1:0]         cfg_pan;
  logic [15:0]        cfg_dur;
  logic [NV-1:0]      active;
  logic signed [15:0] outL;
  logic signed [15:0] outR;
  logic               out_valid;
  logic               overrun;

  dds_tone_mixer dut (
    .CLOCK_50    (CLOCK_50),
    .RST         (RST),
    .sample_tick (sample_tick),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_voice   (cfg_voice),
    .cfg_incr    (cfg_incr),
    .cfg_gain    (cfg_gain),
    .cfg_pan     (cfg_pan),
    .cfg_dur     (cfg_dur),
    .active      (active),
    .outL        (outL),
    .outR        (outR),
    .out_valid   (out_valid),
    .overrun     (overrun)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int unsigned cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {
    longint      l;
    longint      r;
    logic [3:0]  act;
    int unsigned tcyc;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int ov_cnt   = 0;
  int orun_cnt = 0;

  logic [31:0] m_phase [NV];
  logic [31:0] m_incr  [NV];
  int          m_gain  [NV];
  int          m_pan   [NV];
  int          m_dur   [NV];
  logic [3:0]  m_act;

  int tone_exp [4] = '{0, 16383, 0, -16384};
  int sat_exp  [4] = '{0, 32767, 0, -32768};

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int tb_sine(input int k);
    real r;
    r = 32767.0 * $sin(6.283185307179586 * real'(k) / 256.0);
    if (r >= 0.0) return $rtoi(r + 0.5);
    else          return -$rtoi(0.5 - r);
  endfunction

  function automatic longint sat16(input longint a);
    if (a > 32767)  return 32767;
    if (a < -32768) return -32768;
    return a;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_phase[v] = '0;
      m_incr[v]  = '0;
      m_gain[v]  = 0;
      m_pan[v]   = 0;
      m_dur[v]   = 0;
    end
    m_act = '0;
  endtask

  task automatic model_cfg(input int v, input logic [31:0] inc, input int g, input int p, input int d);
    m_phase[v] = '0;
    m_incr[v]  = inc;
    m_gain[v]  = g;
    m_pan[v]   = p;
    m_dur[v]   = d;
    m_act[v]   = (g != 0);
  endtask

  task automatic model_tick(input int unsigned t);
    exp_t   e;
    longint al;
    longint ar;
    int     s;
    int     c;
    al = 0;
    ar = 0;
    for (int v = 0; v < NV; v++) begin
      if (m_act[v]) begin
        s = tb_sine(int'(m_phase[v][31:24]));
        c = (s * m_gain[v]) >>> 4;
        if ((m_pan[v] & 1) != 0) al += c;
        if ((m_pan[v] & 2) != 0) ar += c;
        m_phase[v] = m_phase[v] + m_incr[v];
        if (m_dur[v] != 0) begin
          m_dur[v]--;
          if (m_dur[v] == 0) m_act[v] = 1'b0;
        end
      end
    end
    e.l    = sat16(al);
    e.r    = sat16(ar);
    e.act  = m_act;
    e.tcyc = t;
    sb_q.push_back(e);
  endtask

  always @(negedge CLOCK_50) begin : monitor
    exp_t e;
    if (out_valid === 1'b1) begin
      ov_cnt++;
      if (sb_q.size() == 0) begin
        check("sb_pending", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        check("sb_outL", outL, e.l);
        check("sb_outR", outR, e.r);
        check("sb_active", active, e.act);
        check("sb_latency", cyc - e.tcyc, 7);
      end
    end
    if (overrun === 1'b1) orun_cnt++;
  end

  task automatic do_reset();
    @(posedge CLOCK_50); #1;
    RST = 1'b1;
    sample_tick = 1'b0;
    cfg_valid = 1'b0;
    @(posedge CLOCK_50);
    @(posedge CLOCK_50); #1;
    RST = 1'b0;
    model_reset();
    sb_q.delete();
  endtask

  task automatic cfg_write(input int v, input logic [31:0] inc, input int g, input int p, input int d);
    int ok;
    ok = 0;
    @(posedge CLOCK_50); #1;
    cfg_valid = 1'b1;
    cfg_voice = 2'(v);
    cfg_incr  = inc;
    cfg_gain  = 4'(g);
    cfg_pan   = 2'(p);
    cfg_dur   = 16'(d);
    for (int i = 0; i < 40; i++) begin
      @(negedge CLOCK_50);
      if (cfg_ready) begin
        ok = 1;
        break;
      end
    end
    @(posedge CLOCK_50); #1;
    cfg_valid = 1'b0;
    check("cfg_accept", ok, 1);
    if (ok != 0) model_cfg(v, inc, g, p, d);
  endtask

  task automatic tick_model();
    @(posedge CLOCK_50); #1;
    sample_tick = 1'b1;
    model_tick(cyc);
    @(posedge CLOCK_50); #1;
    sample_tick = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      @(negedge CLOCK_50);
      if (sb_q.size() == 0) break;
    end
    check("pass_drained", sb_q.size(), 0);
    @(posedge CLOCK_50);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int          ov0;
    int          or0;
    int          ok;
    int unsigned t;
    int unsigned acc_cyc;
    RST = 1'b0; sample_tick = 1'b0; cfg_valid = 1'b0; cfg_voice = '0;
    cfg_incr = '0; cfg_gain = '0; cfg_pan = '0; cfg_dur = '0;
    model_reset();

    // reset state
    do_reset();
    @(negedge CLOCK_50);
    check("rst_outL", outL, 0);
    check("rst_outR", outR, 0);
    check("rst_active", active, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_overrun", overrun, 0);

    // single tone, quarter-period increment
    cfg_write(0, 32'h4000_0000, 8, 3, 0);
    for (int i = 0; i < 4; i++) begin
      tick_model();
      wait_idle();
      check("tone_L", outL, tone_exp[i]);
      check("tone_R", outR, tone_exp[i]);
    end

    // four full-gain voices overflow the output range
    do_reset();
    for (int v = 0; v < NV; v++) cfg_write(v, 32'h4000_0000, 15, 3, 0);
    for (int i = 0; i < 4; i++) begin
      tick_model();
      wait_idle();
      check("sat_L", outL, sat_exp[i]);
      check("sat_R", outR, sat_exp[i]);
    end

    // left-only voice with a three-sample note
    do_reset();
    cfg_write(2, 32'h4000_0000, 8, 1, 3);
    for (int i = 0; i < 4; i++) begin
      tick_model();
      wait_idle();
      check("pan_R_zero", outR, 0);
      check("dur_active2", active[2], (i < 2) ? 1 : 0);
      if (i == 3) check("dur_L4", outL, 0);
    end

    // second tick two cycles into a pass is dropped
    do_reset();
    cfg_write(0, 32'h4000_0000, 8, 3, 0);
    ov0 = ov_cnt;
    or0 = orun_cnt;
    @(posedge CLOCK_50); #1;
    sample_tick = 1'b1;
    model_tick(cyc);
    @(posedge CLOCK_50); #1;
    sample_tick = 1'b0;
    @(posedge CLOCK_50); #1;
    sample_tick = 1'b1;
    @(posedge CLOCK_50); #1;
    sample_tick = 1'b0;
    wait_idle();
    repeat (10) @(negedge CLOCK_50);
    check("overrun_pulses", orun_cnt - or0, 1);
    check("overrun_outputs", ov_cnt - ov0, 1);

    // configuration request coincident with a tick waits for the pass
    @(posedge CLOCK_50); #1;
    sample_tick = 1'b1;
    cfg_valid   = 1'b1;
    cfg_voice   = 2'd1;
    cfg_incr    = 32'h2000_0000;
    cfg_gain    = 4'd4;
    cfg_pan     = 2'd2;
    cfg_dur     = 16'd0;
    t = cyc;
    model_tick(t);
    @(negedge CLOCK_50);
    check("contend_ready", cfg_ready, 0);
    @(posedge CLOCK_50); #1;
    sample_tick = 1'b0;
    ok = 0;
    acc_cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge CLOCK_50);
      if (cfg_ready) begin
        ok = 1;
        acc_cyc = cyc;
        break;
      end
    end
    @(posedge CLOCK_50); #1;
    cfg_valid = 1'b0;
    check("contend_accept", ok, 1);
    check("contend_accept_cycle", acc_cyc - t, 7);
    model_cfg(1, 32'h2000_0000, 4, 2, 0);
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      tick_model();
      wait_idle();
    end

    // reset in the middle of a pass
    ov0 = ov_cnt;
    @(posedge CLOCK_50); #1;
    sample_tick = 1'b1;
    model_tick(cyc);
    @(posedge CLOCK_50); #1;
    sample_tick = 1'b0;
    @(posedge CLOCK_50); #1;
    RST = 1'b1;
    @(posedge CLOCK_50); #1;
    RST = 1'b0;
    model_reset();
    sb_q.delete();
    repeat (12) @(negedge CLOCK_50);
    check("midrst_no_output", ov_cnt - ov0, 0);
    check("midrst_outL", outL, 0);
    check("midrst_outR", outR, 0);
    check("midrst_active", active, 0);
    tick_model();
    wait_idle();
    cfg_write(0, 32'h4000_0000, 8, 3, 0);
    for (int i = 0; i < 2; i++) begin
      tick_model();
      wait_idle();
    end
    check("midrst_phase0", outL, 16383);

    // random voice mixes
    do_reset();
    for (int n = 0; n < 8; n++) begin
      cfg_write($urandom_range(0, 3), $urandom(), $urandom_range(0, 15),
                $urandom_range(0, 3), $urandom_range(0, 4));
      for (int i = 0; i < 3; i++) begin
        tick_model();
        wait_idle();
      end
    end

    repeat (5) @(negedge CLOCK_50);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
